fir_xifu_mem_responder: RTL



---
 rtl/fir_xifu_mem_responder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fir_xifu_mem_responder.sv
// fir_xifu_mem_responder
//
// Core-side responder for the X-IF memory channel. Accepts mem_req transactions
// from the XIFU execute stage, re-issues them on an OBI data port, tracks the
// IDs of granted transactions in an in-order FIFO, and returns a registered
// mem_result pulse for each OBI response.
//
// Optional feature macro: FIR_XIFU_MISALIGN_CHECK_EN
//   defined   - word-wide (be=4'b1111) requests with addr[1:0]!=0 are answered
//               with a misaligned exception and never reach the bus.
//   undefined - no check; mem_resp_exc_o / mem_resp_exccode_o tied to 0.
//
// Ports:
//   clk_i, rst_i (sync, active-high), clear_i   clock, reset, soft clear
//   mem_valid_i / mem_ready_o / mem_req_*_i      X-IF memory request
//   mem_resp_exc_o, mem_resp_exccode_o           X-IF response (comb.)
//   mem_result_*_o                               X-IF result (registered pulse)
//   data_*_o / data_*_i                          OBI data port
module fir_xifu_mem_responder #(
    parameter int unsigned ID_WIDTH = 4,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                mem_valid_i,
    output logic                mem_ready_o,
    input  logic [ID_WIDTH-1:0] mem_req_id_i,
    input  logic [31:0]         mem_req_addr_i,
    input  logic                mem_req_we_i,
    input  logic [3:0]          mem_req_be_i,
    input  logic [31:0]         mem_req_wdata_i,
    output logic                mem_resp_exc_o,
    output logic [5:0]          mem_resp_exccode_o,
    output logic                mem_result_valid_o,
    output logic [ID_WIDTH-1:0] mem_result_id_o,
    output logic [31:0]         mem_result_rdata_o,
    output logic                mem_result_err_o,
    output logic                data_req_o,
    input  logic                data_gnt_i,
    output logic [31:0]         data_addr_o,
    output logic                data_we_o,
    output logic [3:0]          data_be_o,
    output logic [31:0]         data_wdata_o,
    input  logic                data_rvalid_i,
    input  logic [31:0]         data_rdata_i,
    input  logic                data_err_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW:0]   DepthOcc = (CntW + 1)'(DEPTH);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);

    typedef enum logic {StIdle, StIssue} state_e;

    // Request FSM and request register
    state_e              r_state;
    logic [ID_WIDTH-1:0] r_id;
    logic [31:0]         r_addr;
    logic                r_we;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;

    // In-order FIFO of granted {id, we}
    logic [ID_WIDTH-1:0] r_fifo_id [DEPTH];
    logic                r_fifo_we [DEPTH];
    logic [PtrW-1:0]     r_wptr;
    logic [PtrW-1:0]     r_rptr;
    logic [CntW-1:0]     r_count;

    // Result register
    logic                r_res_valid;
    logic [ID_WIDTH-1:0] r_res_id;
    logic [31:0]         r_res_rdata;
    logic                r_res_err;

    logic                w_issue;
    logic [CntW:0]       w_occ;
    logic                w_slot_ok;
    logic                w_path_ok;
    logic                w_accept;
    logic                w_misalign;
    logic                w_push;
    logic                w_pop;
    logic [PtrW-1:0]     w_wptr_nxt;
    logic [PtrW-1:0]     w_rptr_nxt;

    assign w_issue = (r_state == StIssue);

    // Occupancy counts the pending request; a pop this cycle is not credited.
    assign w_occ     = {1'b0, r_count} + {{CntW{1'b0}}, w_issue};
    assign w_slot_ok = (w_occ < DepthOcc);
    // In ISSUE a new request can only be taken when the current one is granted.
    assign w_path_ok = !w_issue || data_gnt_i;

    assign mem_ready_o = mem_valid_i && !rst_i && !clear_i && w_slot_ok && w_path_ok;

`ifdef FIR_XIFU_MISALIGN_CHECK_EN
    assign w_misalign         = (mem_req_addr_i[1:0] != 2'b00) && (mem_req_be_i == 4'b1111);
    assign mem_resp_exc_o     = mem_ready_o && w_misalign;
    assign mem_resp_exccode_o = !mem_resp_exc_o ? 6'd0 : (mem_req_we_i ? 6'd6 : 6'd4);
`else
    assign w_misalign         = 1'b0;
    assign mem_resp_exc_o     = 1'b0;
    assign mem_resp_exccode_o = 6'd0;
`endif

    // A misaligned request is acknowledged but leaves FSM and FIFO untouched.
    assign w_accept = mem_ready_o && !w_misalign;
    assign w_push   = w_issue && data_gnt_i;
    assign w_pop    = data_rvalid_i && (r_count != '0);

    assign w_wptr_nxt = (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
    assign w_rptr_nxt = (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;

    // Request FSM with registered bus-side request fields
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_id    <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
        end else begin
            if (w_accept) begin
                r_state <= StIssue;
                r_id    <= mem_req_id_i;
                r_addr  <= mem_req_addr_i;
                r_we    <= mem_req_we_i;
                r_be    <= mem_req_be_i;
                r_wdata <= mem_req_wdata_i;
            end else if (w_issue && (data_gnt_i || clear_i)) begin
                // Grant wins over clear: a granted request is pushed, not dropped.
                r_state <= StIdle;
            end
        end
    end

    // FIFO storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_id[r_wptr] <= r_id;
            r_fifo_we[r_wptr] <= r_we;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_rdata <= '0;
            r_res_err   <= 1'b0;
        end else begin
            r_res_valid <= w_pop;
            if (w_pop) begin
                r_res_id    <= r_fifo_id[r_rptr];
                r_res_rdata <= r_fifo_we[r_rptr] ? 32'h0 : data_rdata_i;
                r_res_err   <= data_err_i;
            end else begin
                r_res_id    <= '0;
                r_res_rdata <= '0;
                r_res_err   <= 1'b0;
            end
        end
    end

    assign data_req_o   = w_issue;
    assign data_addr_o  = r_addr;
    assign data_we_o    = r_we;
    assign data_be_o    = r_be;
    assign data_wdata_o = r_wdata;

    assign mem_result_valid_o = r_res_valid;
    assign mem_result_id_o    = r_res_id;
    assign mem_result_rdata_o = r_res_rdata;
    assign mem_result_err_o   = r_res_err;

`ifndef SYNTHESIS
    // An OBI response with nothing outstanding is a bus protocol violation.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(data_rvalid_i && (r_count == '0)))
            else $error("fir_xifu_mem_responder: data_rvalid_i with no outstanding transaction");
        end
    end
`endif

endmodule
